// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
// Word and address typedefs live in the top module because their widths depend on its parameters.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_t;

  // Fill bit for the default NOP word (all zeros).
  localparam logic IMEM_NOP_FILL = 1'b0;

  // Addresses are widened to 32 bits so that non-power-of-2 depths compare correctly.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// 1R1W synchronous instruction storage.
// There is no reset, so the array can be mapped onto block RAM.
module instr_mem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 9,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // rdata keeps its value whenever re is low; the top level relies on this to hold the output.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory with a host load port and a registered fetch port.
// An IDLE/LOAD/RUN mode FSM selects between loading the program and fetching from it.
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int unsigned ROM_DEPTH   = 256,
  parameter int unsigned INSTR_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH  = $clog2(ROM_DEPTH),
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD = {INSTR_WIDTH{IMEM_NOP_FILL}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_en,
  input  logic                   load_we,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  input  logic                   stall,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic                   addr_fault,
  output logic                   run_mode
);

  typedef logic [INSTR_WIDTH-1:0] instr_t;
  typedef logic [ADDR_WIDTH-1:0]  iaddr_t;

  imem_state_t state;
  instr_t      rd_data;
  logic        nop_sel;
  logic        fetch_ok;
  logic        write_ok;
  logic        fetch_go;
  logic        write_go;
  iaddr_t      rd_addr;

  assign fetch_ok = addr_in_range(32'(fetch_addr), ROM_DEPTH);
  assign write_ok = addr_in_range(32'(load_addr), ROM_DEPTH);

  // A fetch is accepted only in RUN when neither a stall nor a switch back to LOAD is pending.
  assign fetch_go = (state == RUN) && fetch_req && !stall && !load_en;
  assign write_go = (state == LOAD) && load_we;
  assign rd_addr  = fetch_addr;

  instr_mem_array #(
    .DEPTH (ROM_DEPTH),
    .WIDTH (INSTR_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (write_go && write_ok),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (fetch_go && fetch_ok),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // nop_sel masks the RAM output after reset, a flush or an out-of-range fetch.
  assign instr_out = nop_sel ? NOP_WORD : rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      nop_sel     <= 1'b1;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
      run_mode    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) state <= LOAD;
        end
        LOAD: begin
          instr_valid <= 1'b0;
          nop_sel     <= 1'b1;
          if (load_we) addr_fault <= !write_ok;
          if (!load_en) begin
            state    <= RUN;
            run_mode <= 1'b1;
          end
        end
        RUN: begin
          // While stalled every output register simply holds.
          if (!stall) begin
            if (load_en) begin
              state       <= LOAD;
              run_mode    <= 1'b0;
              instr_valid <= 1'b0;
              nop_sel     <= 1'b1;
            end else if (fetch_req) begin
              instr_valid <= 1'b1;
              nop_sel     <= !fetch_ok;
              addr_fault  <= !fetch_ok;
            end else begin
              instr_valid <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
